// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
// Contents: opcode encodings, FSM state enum, err_code encodings and
// default parameter values for AW / DEPTH / IRQ_VEC.
package pc_seq_pkg;

  localparam int          DEF_AW      = 10;
  localparam int          DEF_DEPTH   = 8;
  localparam logic [9:0]  DEF_IRQ_VEC = 10'h3F0;

  localparam logic [2:0] OP_NEXT = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_RETI = 3'b111;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UNF  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO, DEPTH entries of AW bits.
// Ports:
//   clk, reset   clock, async active-high reset (clears count only)
//   push, wdata  write wdata at entry[count]; ignored when full
//   pop          drop entry[count-1]; ignored when empty
//   full, empty  occupancy flags
//   top          entry[count-1] (undefined when empty)
//   count        current occupancy, 0..DEPTH
module ret_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] wdata,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] top,
  output logic [CW-1:0] count
);

  localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] mem_q [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_m1;

  assign count_m1 = count_q - CW'(1);
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign top      = mem_q[count_m1[AIW-1:0]];
  assign count    = count_q;

  // Storage has no reset: only count defines which entries are live.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[count_q[AIW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + CW'(1);
    end else if (pop && !empty) begin
      count_q <= count_m1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with call/return stack and a single
// vectored interrupt.
// Ports:
//   clk, reset         clock, async active-high reset
//   en                 advance enable (0 = stall)
//   op, target, zero   opcode, jump/call destination, zero flag
//   irq / irq_ack      level request / one-cycle take pulse
//   pc, depth, ie      program counter, stack occupancy, interrupt enable
//   halted, err        FSM in HALT / ERROR
//   err_code           01 overflow, 10 underflow, 00 none
//   dbg_state          raw FSM state for observation
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int            AW      = DEF_AW,
  parameter int            DEPTH   = DEF_DEPTH,
  parameter logic [AW-1:0] IRQ_VEC = AW'(DEF_IRQ_VEC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic [AW-1:0] target,
  input  logic          zero,
  input  logic          irq,
  output logic          irq_ack,
  output logic [AW-1:0] pc,
  output logic [3:0]    depth,
  output logic          ie,
  output logic          halted,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic          ie_q, ie_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          ack_q, ack_d;

  logic          push, pop;
  logic [AW-1:0] push_data;
  logic          stk_full, stk_empty;
  logic [AW-1:0] stk_top;
  logic [CW-1:0] stk_count;

  ret_stack #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .full  (stk_full),
    .empty (stk_empty),
    .top   (stk_top),
    .count (stk_count)
  );

  // Natural AW-bit overflow gives the required wrap to 0.
  assign pc_inc = pc_q + AW'(1);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ie_d       = ie_q;
    err_code_d = err_code_q;
    ack_d      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    push_data  = pc_inc;
    if (en) begin
      case (state_q)
        ST_RUN: begin
          if (irq && ie_q && !stk_full) begin
            // Current op is discarded; return re-executes it, so push pc.
            push      = 1'b1;
            push_data = pc_q;
            pc_d      = IRQ_VEC;
            ie_d      = 1'b0;
            ack_d     = 1'b1;
          end else begin
            case (op)
              OP_NEXT: pc_d = pc_inc;
              OP_JMP:  pc_d = target;
              OP_JZ:   pc_d = zero ? target : pc_inc;
              OP_JNZ:  pc_d = zero ? pc_inc : target;
              OP_CALL: begin
                if (stk_full) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_OVF;
                end else begin
                  push = 1'b1;
                  pc_d = target;
                end
              end
              OP_RET, OP_RETI: begin
                if (stk_empty) begin
                  state_d    = ST_ERROR;
                  err_code_d = ERR_UNF;
                end else begin
                  pop  = 1'b1;
                  pc_d = stk_top;
                  if (op == OP_RETI) ie_d = 1'b1;
                end
              end
              OP_HALT: state_d = ST_HALT;
              default: pc_d = pc_inc;
            endcase
          end
        end
        ST_HALT: begin
          // Wake only through an interrupt; return lands after the HALT.
          if (irq && ie_q && !stk_full) begin
            push      = 1'b1;
            push_data = pc_inc;
            pc_d      = IRQ_VEC;
            ie_d      = 1'b0;
            ack_d     = 1'b1;
            state_d   = ST_RUN;
          end
        end
        default: ; // ST_ERROR: frozen until reset
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= '0;
      ie_q       <= 1'b1;
      err_code_q <= ERR_NONE;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ie_q       <= ie_d;
      err_code_q <= err_code_d;
      ack_q      <= ack_d;
    end
  end

  assign pc        = pc_q;
  assign depth     = 4'(stk_count);
  assign ie        = ie_q;
  assign irq_ack   = ack_q;
  assign halted    = (state_q == ST_HALT);
  assign err       = (state_q == ST_ERROR);
  assign err_code  = err_code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam logic [2:0] NEXT = 3'd0, JMP = 3'd1, JZ = 3'd2, JNZ = 3'd3,
                         CALL = 3'd4, RET = 3'd5, HALT = 3'd6, RETI = 3'd7;
  localparam int VEC = 'h3F0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic [2:0] op = 3'd0;
  logic [9:0] target = '0;
  logic       zero = 1'b0;
  logic       irq = 1'b0;
  logic       irq_ack;
  logic [9:0] pc;
  logic [3:0] depth;
  logic       ie, halted, err;
  logic [1:0] err_code;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .target(target),
    .zero(zero), .irq(irq), .irq_ack(irq_ack), .pc(pc), .depth(depth),
    .ie(ie), .halted(halted), .err(err), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  int       m_pc;
  int       m_stk[$];
  logic     m_ie;
  int       m_st;      // 0 running, 1 halted, 2 error
  logic [1:0] m_ec;
  logic     m_ack;

  task automatic model_reset();
    m_pc = 0; m_stk.delete(); m_ie = 1'b1; m_st = 0; m_ec = 2'b00; m_ack = 1'b0;
  endtask

  task automatic model_apply(input logic e, input logic [2:0] o, input int t,
                             input logic z, input logic i);
    m_ack = 1'b0;
    if (!e) return;
    if (m_st == 0) begin
      if (i && m_ie && m_stk.size() < 8) begin
        m_stk.push_back(m_pc); m_pc = VEC; m_ie = 1'b0; m_ack = 1'b1;
      end else begin
        case (o)
          NEXT: m_pc = (m_pc + 1) % 1024;
          JMP:  m_pc = t;
          JZ:   m_pc = z ? t : (m_pc + 1) % 1024;
          JNZ:  m_pc = z ? (m_pc + 1) % 1024 : t;
          CALL: if (m_stk.size() == 8) begin m_st = 2; m_ec = 2'b01; end
                else begin m_stk.push_back((m_pc + 1) % 1024); m_pc = t; end
          HALT: m_st = 1;
          default: if (m_stk.size() == 0) begin m_st = 2; m_ec = 2'b10; end
                   else begin m_pc = m_stk.pop_back(); if (o == RETI) m_ie = 1'b1; end
        endcase
      end
    end else if (m_st == 1) begin
      if (i && m_ie && m_stk.size() < 8) begin
        m_stk.push_back((m_pc + 1) % 1024); m_pc = VEC; m_ie = 1'b0;
        m_ack = 1'b1; m_st = 0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step(input logic e, input logic [2:0] o, input logic [9:0] t,
                      input logic z, input logic i);
    en = e; op = o; target = t; zero = z; irq = i;
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; en = 1'b0; irq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge clk); #1;
    if ({pc, depth, ie, halted, err, err_code, irq_ack} !== {10'd0, 4'd0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0}) begin
      n_fail++; $display("FAIL reset_values: pc=%0d depth=%0d ie=%b halted=%b err=%b code=%b ack=%b", pc, depth, ie, halted, err, err_code, irq_ack);
    end
    n_tests++;
    reset = 1'b0;
    step(1, NEXT, 0, 0, 0);
    if (pc !== 10'd1) begin n_fail++; $display("FAIL first_op_after_reset: pc=%0d expected 1", pc); end
    n_tests++;
    step(1, NEXT, 0, 0, 0);
    step(1, CALL, 10'd40, 0, 0);
    // Assert reset between edges: outputs must clear without a clock.
    #2 reset = 1'b1; #1;
    if ({pc, depth, ie} !== {10'd0, 4'd0, 1'b1}) begin
      n_fail++; $display("FAIL async_reset: pc=%0d depth=%0d ie=%b expected 0 0 1", pc, depth, ie);
    end
    n_tests++;
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_branches();
    step(1, JMP, 10'd5, 0, 0);
    step(1, JZ, 10'd20, 1, 0);
    if (pc !== 10'd20) begin n_fail++; $display("FAIL jz_taken: pc=%0d expected 20", pc); end
    n_tests++;
    step(1, JMP, 10'd5, 0, 0);
    step(1, JZ, 10'd20, 0, 0);
    if (pc !== 10'd6) begin n_fail++; $display("FAIL jz_not_taken: pc=%0d expected 6", pc); end
    n_tests++;
    step(1, JNZ, 10'd300, 0, 0);
    if (pc !== 10'd300) begin n_fail++; $display("FAIL jnz_taken: pc=%0d expected 300", pc); end
    n_tests++;
    step(1, JNZ, 10'd9, 1, 0);
    if (pc !== 10'd301) begin n_fail++; $display("FAIL jnz_not_taken: pc=%0d expected 301", pc); end
    n_tests++;
    step(0, JMP, 10'd77, 0, 1);
    if ({pc, irq_ack, ie} !== {10'd301, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL stall: pc=%0d ack=%b ie=%b expected 301 0 1", pc, irq_ack, ie);
    end
    n_tests++;
    step(1, JMP, 10'd1023, 0, 0);
    step(1, NEXT, 0, 0, 0);
    if (pc !== 10'd0) begin n_fail++; $display("FAIL pc_wrap: pc=%0d expected 0", pc); end
    n_tests++;
  endtask

  task automatic test_call_ret();
    pulse_reset();
    step(1, JMP, 10'd7, 0, 0);
    step(1, CALL, 10'd100, 0, 0);
    if ({pc, depth} !== {10'd100, 4'd1}) begin
      n_fail++; $display("FAIL call: pc=%0d depth=%0d expected 100 1", pc, depth);
    end
    n_tests++;
    step(1, RET, 0, 0, 0);
    if ({pc, depth} !== {10'd8, 4'd0}) begin
      n_fail++; $display("FAIL ret: pc=%0d depth=%0d expected 8 0", pc, depth);
    end
    n_tests++;
    step(1, JMP, 10'd1023, 0, 0);
    step(1, CALL, 10'd12, 0, 0);
    step(1, RET, 0, 0, 0);
    if (pc !== 10'd0) begin n_fail++; $display("FAIL call_push_wrap: pc=%0d expected 0", pc); end
    n_tests++;
  endtask

  task automatic test_overflow();
    pulse_reset();
    for (int k = 0; k < 8; k++) step(1, CALL, 10'(100 + k * 10), 0, 0);
    if ({pc, depth} !== {10'd170, 4'd8}) begin
      n_fail++; $display("FAIL nested_calls: pc=%0d depth=%0d expected 170 8", pc, depth);
    end
    n_tests++;
    // Full stack: interrupt deferred, op runs normally.
    step(1, NEXT, 0, 0, 1);
    if ({pc, irq_ack, err, ie} !== {10'd171, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL irq_deferred: pc=%0d ack=%b err=%b ie=%b expected 171 0 0 1", pc, irq_ack, err, ie);
    end
    n_tests++;
    step(1, CALL, 10'd500, 0, 0);
    if ({pc, err, err_code, depth} !== {10'd171, 1'b1, 2'b01, 4'd8}) begin
      n_fail++; $display("FAIL overflow: pc=%0d err=%b code=%b depth=%0d expected 171 1 01 8", pc, err, err_code, depth);
    end
    n_tests++;
    step(1, NEXT, 0, 0, 0);
    step(1, RET, 0, 0, 1);
    if ({pc, err, err_code, depth, irq_ack} !== {10'd171, 1'b1, 2'b01, 4'd8, 1'b0}) begin
      n_fail++; $display("FAIL error_hold: pc=%0d err=%b code=%b depth=%0d ack=%b", pc, err, err_code, depth, irq_ack);
    end
    n_tests++;
  endtask

  task automatic test_underflow();
    pulse_reset();
    step(1, RET, 0, 0, 0);
    if ({pc, err, err_code} !== {10'd0, 1'b1, 2'b10}) begin
      n_fail++; $display("FAIL ret_underflow: pc=%0d err=%b code=%b expected 0 1 10", pc, err, err_code);
    end
    n_tests++;
    pulse_reset();
    if ({pc, err, ie, err_code} !== {10'd0, 1'b0, 1'b1, 2'b00}) begin
      n_fail++; $display("FAIL reset_from_error: pc=%0d err=%b ie=%b code=%b", pc, err, ie, err_code);
    end
    n_tests++;
    step(1, JMP, 10'd33, 0, 0);
    step(1, NEXT, 0, 0, 1);
    step(1, RET, 0, 0, 0);
    step(1, RETI, 0, 0, 0);
    if ({pc, err, err_code, ie} !== {10'd33, 1'b1, 2'b10, 1'b0}) begin
      n_fail++; $display("FAIL reti_underflow: pc=%0d err=%b code=%b ie=%b expected 33 1 10 0", pc, err, err_code, ie);
    end
    n_tests++;
  endtask

  task automatic test_irq();
    pulse_reset();
    step(1, JMP, 10'd50, 0, 0);
    step(1, JMP, 10'd999, 0, 1);
    if ({pc, irq_ack, ie, depth} !== {10'h3F0, 1'b1, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL irq_take: pc=%0h ack=%b ie=%b depth=%0d expected 3f0 1 0 1", pc, irq_ack, ie, depth);
    end
    n_tests++;
    step(1, NEXT, 0, 0, 1);
    if ({pc, irq_ack, depth} !== {10'h3F1, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL irq_masked: pc=%0h ack=%b depth=%0d expected 3f1 0 1", pc, irq_ack, depth);
    end
    n_tests++;
    step(1, RETI, 0, 0, 0);
    if ({pc, ie, depth} !== {10'd50, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL reti: pc=%0d ie=%b depth=%0d expected 50 1 0", pc, ie, depth);
    end
    n_tests++;
    step(1, NEXT, 0, 0, 1);
    step(0, NEXT, 0, 0, 1);
    if ({pc, irq_ack} !== {10'h3F0, 1'b0}) begin
      n_fail++; $display("FAIL ack_one_cycle: pc=%0h ack=%b expected 3f0 0", pc, irq_ack);
    end
    n_tests++;
  endtask

  task automatic test_halt_irq();
    pulse_reset();
    step(1, JMP, 10'd1023, 0, 0);
    step(1, HALT, 0, 0, 0);
    if ({pc, halted} !== {10'd1023, 1'b1}) begin
      n_fail++; $display("FAIL halt: pc=%0d halted=%b expected 1023 1", pc, halted);
    end
    n_tests++;
    step(0, NEXT, 0, 0, 1);
    step(1, JMP, 10'd5, 0, 0);
    if ({pc, halted, irq_ack, depth} !== {10'd1023, 1'b1, 1'b0, 4'd0}) begin
      n_fail++; $display("FAIL halt_hold: pc=%0d halted=%b ack=%b depth=%0d", pc, halted, irq_ack, depth);
    end
    n_tests++;
    step(1, NEXT, 0, 0, 1);
    if ({pc, halted, irq_ack, ie, depth} !== {10'h3F0, 1'b0, 1'b1, 1'b0, 4'd1}) begin
      n_fail++; $display("FAIL halt_wake: pc=%0h halted=%b ack=%b ie=%b depth=%0d", pc, halted, irq_ack, ie, depth);
    end
    n_tests++;
    step(0, RETI, 0, 0, 0);
    step(0, RETI, 0, 0, 0);
    if ({pc, depth, ie, irq_ack} !== {10'h3F0, 4'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL stall_after_wake: pc=%0h depth=%0d ie=%b ack=%b", pc, depth, ie, irq_ack);
    end
    n_tests++;
    step(1, RETI, 0, 0, 0);
    if ({pc, ie, depth} !== {10'd0, 1'b1, 4'd0}) begin
      n_fail++; $display("FAIL halt_return: pc=%0d ie=%b depth=%0d expected 0 1 0", pc, ie, depth);
    end
    n_tests++;
  endtask

  task automatic test_random();
    logic [19:0] exp_v;
    logic       r_en, r_z, r_i;
    logic [2:0] r_op;
    logic [9:0] r_t;
    pulse_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      if ((m_st == 2 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        pulse_reset();
        model_reset();
      end
      r_en = ($urandom_range(0, 9) != 0);
      r_op = 3'($urandom_range(0, 7));
      r_t  = 10'($urandom_range(0, 1023));
      r_z  = 1'($urandom_range(0, 1));
      r_i  = ($urandom_range(0, 6) == 0);
      step(r_en, r_op, r_t, r_z, r_i);
      model_apply(r_en, r_op, int'(r_t), r_z, r_i);
      exp_v = {10'(m_pc), 4'(m_stk.size()), m_ie, (m_st == 1), (m_st == 2), m_ec, m_ack};
      if ({pc, depth, ie, halted, err, err_code, irq_ack} !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d]: got pc=%0d d=%0d ie=%b h=%b e=%b c=%b a=%b want pc=%0d d=%0d ie=%b h=%b e=%b c=%b a=%b",
                 c, pc, depth, ie, halted, err, err_code, irq_ack,
                 exp_v[19:10], exp_v[9:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2:1], exp_v[0]);
      end
      n_tests++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_branches();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_irq();
    test_halt_irq();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter AW, default 10: program-counter and return-address width.
REQ-002 Parameter DEPTH, default 8: return-stack entries.
REQ-003 Parameter IRQ_VEC, default 10'h3F0: interrupt handler address.
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-high.
REQ-006 en  in  1  advance enable; 0 = stall, no state change.
REQ-007 op  in  3  opcode: 000 NEXT, 001 JMP, 010 JZ, 011 JNZ, 100 CALL, 101 RET, 110 HALT, 111 RETI.
REQ-008 target  in  AW  jump/call destination.
REQ-009 zero  in  1  zero flag from the flag flip-flop.
REQ-010 irq  in  1  level interrupt request.
REQ-011 irq_ack  out  1  one-cycle pulse when an interrupt is taken.
REQ-012 pc  out  AW  current program counter.
REQ-013 depth  out  4  return-stack occupancy, 0..DEPTH.
REQ-014 ie  out  1  interrupt enable.
REQ-015 halted  out  1  high in HALT state.
REQ-016 err  out  1  high in ERROR state; err_code out 2: 01 overflow, 10 underflow, 00 none.

Function
REQ-017 FSM states: RUN, HALT, ERROR; all updates only on rising clk edges with en=1.
REQ-018 RUN, no interrupt: NEXT -> pc+1; JMP -> target; JZ -> target if zero=1, else pc+1; JNZ -> target if zero=0, else pc+1.
REQ-019 CALL: push pc+1, pc<=target, depth+1; with depth=DEPTH: no push, pc holds, ERROR, err_code=01.
REQ-020 RET: pc<=top entry, depth-1; with depth=0: pc holds, ERROR, err_code=10.
REQ-021 HALT: pc holds, state HALT, halted=1.
REQ-022 RETI: as RET, plus ie<=1 on success; underflow as REQ-020, ie unchanged.
REQ-023 pc+1 wraps modulo 2^AW (1023+1 -> 0); pushed pc+1 wraps identically.
REQ-024 Interrupt taken in RUN when en=1, irq=1, ie=1, depth<DEPTH: op discarded, push pc, pc<=IRQ_VEC, ie<=0, irq_ack=1 for that cycle.
REQ-025 irq=1 with depth=DEPTH: interrupt deferred, op executes normally, no ack, no error.
REQ-026 HALT state: irq=1, ie=1, en=1, depth<DEPTH -> push pc+1, pc<=IRQ_VEC, ie<=0, irq_ack pulse, state RUN; otherwise hold.
REQ-027 ERROR state: all outputs hold; exits only via reset.
REQ-028 en=0: pc, depth, ie, state, stack unchanged; irq_ack=0.
REQ-029 Stack: LIFO; push writes entry[depth], pop reads entry[depth-1]; one operation per cycle.
REQ-030 Outputs registered, except irq_ack, which is registered from the cycle the interrupt is taken and is high exactly one cycle.

Reset
REQ-031 reset=1 forces, without clk: pc=0, depth=0, ie=1, state RUN, irq_ack=0, halted=0, err=0, err_code=00.
REQ-032 Reset mid-operation (during a push, or in HALT/ERROR) discards the operation; stack contents are don't-care after reset.
REQ-033 First edge after reset deassertion with en=1 executes the op at pc=0.

Structure
REQ-034 Package pc_seq_pkg: opcode constants, FSM state enum, err_code constants, default AW/DEPTH/IRQ_VEC.
REQ-035 One sub-module, ret_stack: DEPTH x AW LIFO with push, pop, full, empty, top, count; async reset of count only.
REQ-036 Top level holds the FSM, the pc register, ie and next-pc selection only.

Verification
REQ-037 pc=5; JZ target=20 with zero=1 -> pc=20; repeat at pc=5 with zero=0 -> pc=6.
REQ-038 CALL target=100 at pc=7 -> pc=100, depth=1; RET -> pc=8, depth=0.
REQ-039 Eight nested CALLs -> depth=8; ninth CALL -> err=1, err_code=01, pc unchanged; then NEXT -> pc still unchanged.
REQ-040 RET at depth=0 -> err=1, err_code=10; pulse reset -> pc=0, err=0, ie=1.
REQ-041 pc=50, irq=1, ie=1 -> pc=0x3F0, irq_ack one cycle, ie=0, depth+1; RETI -> pc=50, ie=1.
REQ-042 HALT at pc=1023 -> halted=1; irq=1 -> pushed 0, pc=0x3F0, halted=0; en=0 cycles -> no change.
